// File: rtl/i2c_arb_pkg.sv
// Shared constants and types for the I2C transaction arbiter.
package i2c_arb_pkg;

  // Bit positions inside a 10-bit TX command word.
  localparam int STOP_BIT  = 9;
  localparam int START_BIT = 8;
  localparam int RD_BIT    = 0;

  // Owner field width covers the largest supported requester count (8).
  localparam int OWNER_W = 3;

  // Transaction lock state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    CNT  = 2'd2
  } arb_state_e;

  // One outstanding read: who issued it and how many bytes it expects.
  typedef struct packed {
    logic [OWNER_W-1:0] owner;
    logic [7:0]         cnt;
  } ord_entry_t;

endpackage

// File: rtl/i2c_arb_ord_fifo.sv
// Ordering FIFO of outstanding read transactions; head stays put until popped.
module i2c_arb_ord_fifo
  import i2c_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_push,
  input  ord_entry_t i_push_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output ord_entry_t o_head
);

  ord_entry_t  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; clear wins over traffic so a flush leaves the queue empty.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter granting whole I2C transactions into one TX FIFO and
// steering RX bytes back to the requester that issued each read.
// Handshakes: a word/byte transfers in a cycle where valid and ready are both 1;
// valid never depends on ready, and the data stays stable while valid waits.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int ORD_DEPTH = 4,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cr_en,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*10-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tx_fifo_full,
  output logic              tx_fifo_wr,
  output logic [9:0]        tx_fifo_din,
  input  logic              rx_fifo_empty,
  input  logic [7:0]        rx_fifo_dout,
  output logic              rx_fifo_rd,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_last,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              busy,
  output logic              err_proto,
  output logic              err_zero_cnt,
  output arb_state_e        dbg_state,
  output logic [IDW-1:0]    dbg_rr_ptr
);

  arb_state_e     r_state, w_state_nxt;
  logic [IDW-1:0] r_gnt, w_gnt_nxt;
  logic [IDW-1:0] r_rr_ptr, w_rr_nxt;
  logic [9:0]     w_words [NREQ];
  logic [IDW-1:0] w_scan_idx [NREQ];
  logic           w_cand_found;
  logic [IDW-1:0] w_cand_idx;
  logic           w_en;
  logic [9:0]     w_gnt_word;
  logic           w_gnt_acc;
  logic [IDW-1:0] w_gnt_inc;
  logic           w_push;
  ord_entry_t     w_push_entry;
  logic           w_ord_pop, w_ord_full, w_ord_empty;
  ord_entry_t     w_ord_head;
  logic           r_active;
  logic [7:0]     r_rem;
  logic [OWNER_W-1:0] r_own;

  // Strobes are suppressed while reset or flush is asserted.
  assign w_en       = ~rst & ~flush;
  assign w_gnt_word = w_words[r_gnt];
  assign w_gnt_acc  = req_valid[r_gnt] & ~tx_fifo_full;
  assign w_gnt_inc  = (r_gnt == IDW'(NREQ-1)) ? '0 : r_gnt + IDW'(1);
  assign busy       = (r_state != IDLE) | r_active | ~w_ord_empty;
  assign dbg_state  = r_state;
  assign dbg_rr_ptr = r_rr_ptr;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign w_words[gi]    = req_data[gi*10 +: 10];
    assign w_scan_idx[gi] = IDW'((int'(r_rr_ptr) + gi) % NREQ);
  end

  // First start-word candidate at or after the round-robin pointer.
  always_comb begin
    w_cand_found = 1'b0;
    w_cand_idx   = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_cand_found && req_valid[w_scan_idx[k]] &&
          w_words[w_scan_idx[k]][START_BIT]) begin
        w_cand_found = 1'b1;
        w_cand_idx   = w_scan_idx[k];
      end
    end
  end

  // Lock FSM: next state, grant, pointer and TX-side strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_rr_nxt     = r_rr_ptr;
    req_ready    = '0;
    tx_fifo_wr   = 1'b0;
    tx_fifo_din  = '0;
    err_proto    = 1'b0;
    err_zero_cnt = 1'b0;
    w_push       = 1'b0;
    w_push_entry = '{owner: OWNER_W'(r_gnt), cnt: w_gnt_word[7:0]};
    if (w_en) begin
      case (r_state)
        IDLE: begin
          // Orphan data at the pointer would block its requester forever; drop it.
          if (req_valid[r_rr_ptr] && !w_words[r_rr_ptr][START_BIT]) begin
            req_ready[r_rr_ptr] = 1'b1;
            err_proto           = 1'b1;
          end
          if (cr_en && w_cand_found) begin
            w_gnt_nxt   = w_cand_idx;
            w_state_nxt = XFER;
          end
        end
        XFER: begin
          tx_fifo_din = w_gnt_word;
          if (w_gnt_acc) begin
            req_ready[r_gnt] = 1'b1;
            tx_fifo_wr       = 1'b1;
            if (w_gnt_word[STOP_BIT]) begin
              w_state_nxt = IDLE;
              w_rr_nxt    = w_gnt_inc;
            end else if (w_gnt_word[START_BIT] && w_gnt_word[RD_BIT]) begin
              w_state_nxt = CNT;
            end
          end
        end
        CNT: begin
          tx_fifo_din = w_gnt_word;
          if (w_gnt_acc && (!w_ord_full || w_ord_pop)) begin
            req_ready[r_gnt] = 1'b1;
            tx_fifo_wr       = 1'b1;
            if (w_gnt_word[7:0] != 8'h00) w_push = 1'b1;
            else                          err_zero_cnt = 1'b1;
            if (w_gnt_word[STOP_BIT]) begin
              w_state_nxt = IDLE;
              w_rr_nxt    = w_gnt_inc;
            end else begin
              w_state_nxt = XFER;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Lock state registers; flush returns to IDLE but keeps the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else if (flush) begin
      r_state  <= IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  i2c_arb_ord_fifo #(.DEPTH(ORD_DEPTH)) u_ord_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (flush),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_ord_pop),
    .o_full      (w_ord_full),
    .o_empty     (w_ord_empty),
    .o_head      (w_ord_head)
  );

  // RX steering: offer the head byte to the owner of the active read.
  always_comb begin
    rsp_valid  = '0;
    rsp_data   = '0;
    rsp_last   = 1'b0;
    rx_fifo_rd = 1'b0;
    w_ord_pop  = 1'b0;
    if (w_en && r_active) begin
      rsp_data = rx_fifo_dout;
      rsp_last = (r_rem == 8'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (r_own == OWNER_W'(i)) begin
          rsp_valid[i] = ~rx_fifo_empty;
          rx_fifo_rd   = ~rx_fifo_empty & rsp_ready[i];
        end
      end
      // The entry leaves the ordering FIFO only once its last byte is taken.
      w_ord_pop = rx_fifo_rd & (r_rem == 8'd1);
    end
  end

  // Active read tracking: load from the FIFO head, count down per popped byte.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_active <= 1'b0;
      r_rem    <= '0;
      r_own    <= '0;
    end else if (!r_active && !w_ord_empty) begin
      r_active <= 1'b1;
      r_rem    <= w_ord_head.cnt;
      r_own    <= w_ord_head.owner;
    end else if (rx_fifo_rd) begin
      r_rem <= r_rem - 8'd1;
      if (r_rem == 8'd1) r_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter (NREQ=4, ORD_DEPTH=2).
module tb_i2c_txn_arbiter;
  import i2c_arb_pkg::*;

  localparam int NREQ      = 4;
  localparam int ORD_DEPTH = 2;
  localparam int IDW       = 2;

  logic              clk = 1'b0;
  logic              rst, cr_en, flush;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*10-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_fifo_full, tx_fifo_wr;
  logic [9:0]        tx_fifo_din;
  logic              rx_fifo_empty, rx_fifo_rd;
  logic [7:0]        rx_fifo_dout;
  logic [NREQ-1:0]   rsp_valid, rsp_ready;
  logic [7:0]        rsp_data;
  logic              rsp_last, busy, err_proto, err_zero_cnt;
  arb_state_e        dbg_state;
  logic [IDW-1:0]    dbg_rr_ptr;

  // Scoreboard and source models.
  logic [9:0]        src_q [NREQ][$];
  logic [7:0]        rx_q[$];
  logic [9:0]        exp_tx_q[$];
  logic [NREQ+8:0]   exp_rsp_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                n_err_proto = 0;
  int                n_err_zero  = 0;
  logic              rand_rsp = 1'b0;
  logic              s_wr, s_rd;
  logic [NREQ-1:0]   s_ready, s_rsp_valid;

  i2c_txn_arbiter #(.NREQ(NREQ), .ORD_DEPTH(ORD_DEPTH)) dut (
    .clk(clk), .rst(rst), .cr_en(cr_en), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_wr(tx_fifo_wr), .tx_fifo_din(tx_fifo_din),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_dout(rx_fifo_dout), .rx_fifo_rd(rx_fifo_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
    .busy(busy), .err_proto(err_proto), .err_zero_cnt(err_zero_cnt),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish");
    $fatal(1);
  end

  // Present queue heads to the DUT.
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (src_q[i].size() > 0);
      req_data[i*10 +: 10] = (src_q[i].size() > 0) ? src_q[i][0] : 10'h000;
    end
    rx_fifo_empty = (rx_q.size() == 0);
    rx_fifo_dout  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    if (rand_rsp) rsp_ready = ($urandom_range(0, 1) == 1) ? '1 : '0;
  endtask

  // One clock: sample at negedge, score outputs, advance sources after posedge.
  task automatic step();
    logic [NREQ-1:0] acc;
    logic [9:0]      e_tx;
    logic [NREQ+8:0] e_rsp;
    @(negedge clk);
    acc         = req_valid & req_ready;
    s_wr        = tx_fifo_wr;
    s_rd        = rx_fifo_rd;
    s_ready     = req_ready;
    s_rsp_valid = rsp_valid;
    if (err_proto    === 1'b1) n_err_proto++;
    if (err_zero_cnt === 1'b1) n_err_zero++;
    if (tx_fifo_wr === 1'b1) begin
      n_checks++;
      if (exp_tx_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_word: got %h, expected no write", tx_fifo_din);
      end else begin
        e_tx = exp_tx_q.pop_front();
        if (tx_fifo_din !== e_tx) begin
          n_fail++;
          $display("FAIL tx_word: got %h, expected %h", tx_fifo_din, e_tx);
        end
      end
    end
    if (rsp_valid !== '0) begin
      n_checks++;
      if (exp_rsp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_byte: got valid=%b data=%h, expected no response", rsp_valid, rsp_data);
      end else begin
        e_rsp = exp_rsp_q[0];
        if ({rsp_valid, rsp_data, rsp_last} !== e_rsp) begin
          n_fail++;
          $display("FAIL rsp_byte: got {valid,data,last}=%h, expected %h",
                   {rsp_valid, rsp_data, rsp_last}, e_rsp);
        end
        if (rx_fifo_rd === 1'b1) void'(exp_rsp_q.pop_front());
      end
    end else if (rx_fifo_rd !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_pop: got rx_fifo_rd=%b with no rsp_valid, expected 0", rx_fifo_rd);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) void'(src_q[i].pop_front());
    if (s_rd === 1'b1 && rx_q.size() > 0) void'(rx_q.pop_front());
    drive();
  endtask

  task automatic run_until_done(input int budget, input string name);
    int  n = 0;
    logic pend = 1'b1;
    while (pend && n < budget) begin
      pend = (exp_tx_q.size() != 0) || (exp_rsp_q.size() != 0) || (busy !== 1'b0);
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) pend = 1'b1;
      if (pend) begin
        step();
        n++;
      end
    end
    n_checks++;
    if (pend) begin
      n_fail++;
      $display("FAIL %s_drain: still pending after %0d cycles, expected drained", name, n);
    end
  endtask

  task automatic apply_reset();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    rx_q.delete();
    exp_tx_q.delete();
    exp_rsp_q.delete();
    rst = 1'b1; cr_en = 1'b1; flush = 1'b0; tx_fifo_full = 1'b0;
    rsp_ready = '1; rand_rsp = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cr_en = 1'b1; flush = 1'b0; tx_fifo_full = 1'b0;
    req_valid = '1;
    req_data  = {10'h055, 10'h1A0, 10'h066, 10'h077};
    rx_fifo_empty = 1'b0; rx_fifo_dout = 8'h5A; rsp_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 6;
    if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready); end
    if ({tx_fifo_wr, tx_fifo_din} !== 11'h0) begin n_fail++; $display("FAIL reset_tx: got wr=%b din=%h, expected 0", tx_fifo_wr, tx_fifo_din); end
    if ({rx_fifo_rd, rsp_valid, rsp_data, rsp_last} !== '0) begin n_fail++; $display("FAIL reset_rx: got rd=%b valid=%b data=%h last=%b, expected 0", rx_fifo_rd, rsp_valid, rsp_data, rsp_last); end
    if ({busy, err_proto, err_zero_cnt} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got busy/proto/zero=%b%b%b, expected 000", busy, err_proto, err_zero_cnt); end
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, expected IDLE", dbg_state); end
    if (dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d, expected 0", dbg_rr_ptr); end
    apply_reset();
  endtask

  task automatic test_single_write();
    int n = 0;
    src_q[0] = '{10'h1A0, 10'h055, 10'h2AA};
    exp_tx_q = '{10'h1A0, 10'h055, 10'h2AA};
    drive();
    while (exp_tx_q.size() > 0 && n < 20) begin step(); n++; end
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL single_write_cycles: got %0d, expected 4", n); end
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL single_write_release: got busy=%b state=%0d, expected 0/IDLE", busy, dbg_state); end
    if (dbg_rr_ptr !== 2'd1) begin n_fail++; $display("FAIL single_write_rr: got %0d, expected 1", dbg_rr_ptr); end
  endtask

  task automatic test_contention();
    apply_reset();
    src_q[1] = '{10'h1B0, 10'h011, 10'h212};
    src_q[2] = '{10'h1C0, 10'h021, 10'h222};
    exp_tx_q = '{10'h1B0, 10'h011, 10'h212, 10'h1C0, 10'h021, 10'h222};
    drive();
    run_until_done(40, "contention");
    n_checks++;
    if (dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL contention_rr: got %0d, expected 3", dbg_rr_ptr); end
  endtask

  task automatic test_read();
    src_q[3]  = '{10'h1A1, 10'h203};
    exp_tx_q  = '{10'h1A1, 10'h203};
    rx_q      = '{8'h11, 8'h22, 8'h33};
    exp_rsp_q = '{{4'b1000, 8'h11, 1'b0}, {4'b1000, 8'h22, 1'b0}, {4'b1000, 8'h33, 1'b1}};
    rand_rsp  = 1'b1;
    drive();
    run_until_done(80, "read");
    rand_rsp  = 1'b0;
    rsp_ready = '1;
    n_checks += 2;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL read_rx_left: got %0d bytes, expected 0", rx_q.size()); end
    if (dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL read_rr: got %0d, expected 0", dbg_rr_ptr); end
  endtask

  task automatic test_backpressure();
    src_q[0] = '{10'h1A0, 10'h001, 10'h002, 10'h003, 10'h204};
    exp_tx_q = '{10'h1A0, 10'h001, 10'h002, 10'h003, 10'h204};
    drive();
    repeat (3) step();
    tx_fifo_full = 1'b1;
    repeat (5) begin
      step();
      n_checks += 2;
      if (s_wr !== 1'b0) begin n_fail++; $display("FAIL bp_wr: got %b, expected 0", s_wr); end
      if (s_ready !== '0) begin n_fail++; $display("FAIL bp_ready: got %b, expected 0", s_ready); end
    end
    tx_fifo_full = 1'b0;
    run_until_done(30, "backpressure");
    n_checks++;
    if (dbg_rr_ptr !== 2'd1) begin n_fail++; $display("FAIL bp_rr: got %0d, expected 1", dbg_rr_ptr); end
  endtask

  task automatic test_ord_full();
    int n = 0;
    int base;
    base = n_err_zero;
    src_q[0] = '{10'h1A1, 10'h201, 10'h1A1, 10'h201, 10'h1A1, 10'h201};
    exp_tx_q = '{10'h1A1, 10'h201, 10'h1A1, 10'h201, 10'h1A1, 10'h201};
    drive();
    while (exp_tx_q.size() > 1 && n < 40) begin step(); n++; end
    repeat (4) step();
    n_checks += 3;
    if (exp_tx_q.size() != 1) begin n_fail++; $display("FAIL ord_stall: got %0d words pending, expected 1", exp_tx_q.size()); end
    if (s_ready[0] !== 1'b0) begin n_fail++; $display("FAIL ord_stall_ready: got %b, expected 0", s_ready[0]); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ord_stall_busy: got %b, expected 1", busy); end
    rx_q.push_back(8'hA1);
    exp_rsp_q.push_back({4'b0001, 8'hA1, 1'b1});
    drive();
    step();
    n_checks++;
    if (exp_tx_q.size() != 0) begin n_fail++; $display("FAIL ord_push_on_pop: got %0d words pending, expected 0", exp_tx_q.size()); end
    rx_q.push_back(8'hA2);
    rx_q.push_back(8'hA3);
    exp_rsp_q.push_back({4'b0001, 8'hA2, 1'b1});
    exp_rsp_q.push_back({4'b0001, 8'hA3, 1'b1});
    drive();
    run_until_done(40, "ord_full");
    n_checks++;
    if (n_err_zero != base) begin n_fail++; $display("FAIL ord_no_zero: got %0d pulses, expected 0", n_err_zero - base); end
    src_q[2] = '{10'h1A1, 10'h200};
    exp_tx_q = '{10'h1A1, 10'h200};
    drive();
    run_until_done(20, "zero_cnt");
    n_checks += 2;
    if (n_err_zero - base != 1) begin n_fail++; $display("FAIL zero_cnt_pulse: got %0d pulses, expected 1", n_err_zero - base); end
    if (dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL zero_cnt_rr: got %0d, expected 3", dbg_rr_ptr); end
  endtask

  task automatic test_flush();
    int n = 0;
    int base;
    rsp_ready = '0;
    src_q[3] = '{10'h1A1, 10'h002, 10'h1A1, 10'h003};
    exp_tx_q = '{10'h1A1, 10'h002, 10'h1A1, 10'h003};
    drive();
    while (exp_tx_q.size() > 0 && n < 30) begin step(); n++; end
    n_checks += 2;
    if (dbg_state !== XFER) begin n_fail++; $display("FAIL flush_pre_state: got %0d, expected XFER", dbg_state); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b, expected 1", busy); end
    rx_q.push_back(8'h77);
    rsp_ready = '1;
    flush = 1'b1;
    drive();
    step();
    flush = 1'b0;
    n_checks++;
    if ({s_wr, s_rd, s_ready, s_rsp_valid} !== '0) begin n_fail++; $display("FAIL flush_strobes: got wr=%b rd=%b ready=%b rsp_valid=%b, expected 0", s_wr, s_rd, s_ready, s_rsp_valid); end
    @(negedge clk);
    n_checks += 3;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL flush_state: got %0d, expected IDLE", dbg_state); end
    if ({rsp_valid, busy} !== '0) begin n_fail++; $display("FAIL flush_idle: got rsp_valid=%b busy=%b, expected 0", rsp_valid, busy); end
    if (dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL flush_rr: got %0d, expected 3", dbg_rr_ptr); end
    rx_q.delete();
    base = n_err_proto;
    src_q[3].push_back(10'h055);
    drive();
    step();
    step();
    n_checks += 2;
    if (n_err_proto - base != 1) begin n_fail++; $display("FAIL proto_pulse: got %0d pulses, expected 1", n_err_proto - base); end
    if (src_q[3].size() != 0) begin n_fail++; $display("FAIL proto_drop: got %0d words left, expected 0", src_q[3].size()); end
  endtask

  initial begin
    req_valid = '0; req_data = '0; rsp_ready = '1;
    rx_fifo_empty = 1'b1; rx_fifo_dout = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_read();
    test_backpressure();
    test_ord_full();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
